// File: rtl/bus_cycle_arbiter_if.sv
// Bus-side signal bundle of the bus cycle arbiter.
// The master modport is the arbiter's view; slave is the requester/bus-interface view.
interface bus_cycle_arbiter_if;
    logic       euReq;
    logic [1:0] euKind;
    logic       euWord;
    logic       intaReq;
    logic       qFull;
    logic       suspend;
    logic       HOLD;
    logic       lockIn;
    logic       busDone;
    logic       busStart;
    logic [2:0] busKind;
    logic       busHighByte;
    logic       euAck;
    logic       intaAck;
    logic       HOLDA;
    logic [2:0] arbState;

    modport master (
        input  euReq, euKind, euWord, intaReq, qFull, suspend, HOLD, lockIn, busDone,
        output busStart, busKind, busHighByte, euAck, intaAck, HOLDA, arbState
    );

    modport slave (
        output euReq, euKind, euWord, intaReq, qFull, suspend, HOLD, lockIn, busDone,
        input  busStart, busKind, busHighByte, euAck, intaAck, HOLDA, arbState
    );
endinterface

// File: rtl/bus_cycle_arbiter.sv
// Bus cycle arbiter: sequences prefetch, EU byte/word, two-cycle INTA and HOLD handover.
// Optional feature: define BUS_ARB_LOCK_EN so that lockIn blocks the HOLD grant.
module bus_cycle_arbiter (
    input  logic                CLKx4,
    input  logic                RESET_n,
    bus_cycle_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EU_LO   = 3'd2,
        EU_HI   = 3'd3,
        INTA1   = 3'd4,
        INTA2   = 3'd5,
        HOLDING = 3'd6
    } arbState_e;

    arbState_e  state_r;
    arbState_e  next_s;
    logic       armed_r;
    logic [1:0] euKind_r;
    logic       euWord_r;
    logic       holdGrant_s;
    logic [1:0] kindSel_s;

    logic       busStart_s;
    logic [2:0] busKind_s;
    logic       busHighByte_s;
    logic       euAck_s;
    logic       intaAck_s;
    logic       holda_s;

    logic       busStart_r;
    logic [2:0] busKind_r;
    logic       busHighByte_r;
    logic       euAck_r;
    logic       intaAck_r;
    logic       holda_r;

`ifdef BUS_ARB_LOCK_EN
    assign holdGrant_s = bus.HOLD & ~bus.lockIn;
`else
    logic unusedLockIn_s;
    assign unusedLockIn_s = bus.lockIn;
    assign holdGrant_s    = bus.HOLD;
`endif

    // State register; armed_r keeps the first edge after reset free of arbitration.
    always_ff @(posedge CLKx4 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r  <= IDLE;
            armed_r  <= 1'b0;
            euKind_r <= 2'b00;
            euWord_r <= 1'b0;
        end else begin
            state_r <= next_s;
            armed_r <= 1'b1;
            if ((state_r == IDLE) && (next_s == EU_LO)) begin
                euKind_r <= bus.euKind;
                euWord_r <= bus.euWord;
            end
        end
    end

    // Next-state logic: arbitration only in IDLE, sequences advance on busDone.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!armed_r) begin
                    next_s = IDLE;
                end else if (holdGrant_s) begin
                    next_s = HOLDING;
                end else if (bus.intaReq) begin
                    next_s = INTA1;
                end else if (bus.euReq) begin
                    next_s = EU_LO;
                end else if (!bus.qFull && !bus.suspend) begin
                    next_s = FETCH;
                end else begin
                    next_s = IDLE;
                end
            end
            FETCH:   next_s = bus.busDone ? IDLE : FETCH;
            EU_LO: begin
                if (bus.busDone) begin
                    next_s = euWord_r ? EU_HI : IDLE;
                end else begin
                    next_s = EU_LO;
                end
            end
            EU_HI:   next_s = bus.busDone ? IDLE : EU_HI;
            INTA1:   next_s = bus.busDone ? INTA2 : INTA1;
            INTA2:   next_s = bus.busDone ? IDLE : INTA2;
            HOLDING: next_s = bus.HOLD ? HOLDING : IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        busStart_s = 1'b0;
        busKind_s  = 3'b000;
        kindSel_s  = (state_r == IDLE) ? bus.euKind : euKind_r;
        case (next_s)
            FETCH:        busKind_s = 3'b000;
            EU_LO, EU_HI: busKind_s = {1'b0, kindSel_s} + 3'b001;
            INTA1, INTA2: busKind_s = 3'b101;
            default:      busKind_s = 3'b000;
        endcase
        if (next_s != state_r) begin
            case (next_s)
                FETCH, EU_LO, EU_HI, INTA1, INTA2: busStart_s = 1'b1;
                default:                           busStart_s = 1'b0;
            endcase
        end else begin
            busStart_s = 1'b0;
        end
        busHighByte_s = (next_s == EU_HI);
        euAck_s       = (next_s == IDLE) && ((state_r == EU_LO) || (state_r == EU_HI));
        intaAck_s     = (next_s == IDLE) && (state_r == INTA2);
        holda_s       = (next_s == HOLDING);
    end

    // Output registers.
    always_ff @(posedge CLKx4 or negedge RESET_n) begin
        if (!RESET_n) begin
            busStart_r    <= 1'b0;
            busKind_r     <= 3'b000;
            busHighByte_r <= 1'b0;
            euAck_r       <= 1'b0;
            intaAck_r     <= 1'b0;
            holda_r       <= 1'b0;
        end else begin
            busStart_r    <= busStart_s;
            busKind_r     <= busKind_s;
            busHighByte_r <= busHighByte_s;
            euAck_r       <= euAck_s;
            intaAck_r     <= intaAck_s;
            holda_r       <= holda_s;
        end
    end

    assign bus.busStart    = busStart_r;
    assign bus.busKind     = busKind_r;
    assign bus.busHighByte = busHighByte_r;
    assign bus.euAck       = euAck_r;
    assign bus.intaAck     = intaAck_r;
    assign bus.HOLDA       = holda_r;
    assign bus.arbState    = state_r;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Self-checking bench for bus_cycle_arbiter: directed scenarios plus randomized request mixes
// checked against a transaction-level expectation queue.
module tb_bus_cycle_arbiter;

    logic CLKx4 = 1'b0;
    logic RESET_n;
    int   checks = 0;
    int   errors = 0;
    int   nStart = 0;
    int   nEuAck = 0;
    int   nIntaAck = 0;

    bus_cycle_arbiter_if bif ();

    bus_cycle_arbiter dut (
        .CLKx4   (CLKx4),
        .RESET_n (RESET_n),
        .bus     (bif)
    );

    always #5 CLKx4 = ~CLKx4;

    // Pulse counters, sampled on the edge that ends each cycle.
    always @(posedge CLKx4) begin
        if (bif.busStart === 1'b1) nStart++;
        if (bif.euAck === 1'b1) nEuAck++;
        if (bif.intaAck === 1'b1) nIntaAck++;
    end

    typedef struct {
        logic [2:0] kind;
        logic       hi;
        int         gap;
        int         ack;
    } exp_t;

    task automatic tick();
        @(posedge CLKx4);
        #1;
    endtask

    task automatic idle_inputs();
        bif.euReq   = 1'b0;
        bif.euKind  = 2'b00;
        bif.euWord  = 1'b0;
        bif.intaReq = 1'b0;
        bif.qFull   = 1'b1;
        bif.suspend = 1'b0;
        bif.HOLD    = 1'b0;
        bif.lockIn  = 1'b0;
        bif.busDone = 1'b0;
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (bif.busStart !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic serve(input int lat);
        repeat (lat - 1) tick();
        bif.busDone = 1'b1;
        tick();
        bif.busDone = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bif.qFull = 1'b0;
        RESET_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bif.busStart, bif.busKind, bif.busHighByte, bif.euAck, bif.intaAck, bif.HOLDA} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {bif.busStart, bif.busKind, bif.busHighByte, bif.euAck, bif.intaAck, bif.HOLDA});
        end
        RESET_n = 1'b1;
        tick();
        checks++;
        if (bif.busStart !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge_idle: busStart got %b want 0", bif.busStart);
        end
        tick();
        checks++;
        if ({bif.busStart, bif.busKind} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_second_edge_fetch: start/kind got %b want 1000", {bif.busStart, bif.busKind});
        end
        bif.qFull = 1'b1;
        serve(2);
        repeat (2) tick();
    endtask

    task automatic test_eu_word();
        int n;
        int s0 = nStart;
        int a0 = nEuAck;
        bif.euReq  = 1'b1;
        bif.euKind = 2'b01;
        bif.euWord = 1'b1;
        wait_start(10, n);
        checks++;
        if (n !== 1 || {bif.busKind, bif.busHighByte} !== 4'b0100) begin
            errors++;
            $display("FAIL euword_lo: wait %0d kind/hi %b want wait 1 kind/hi 0100", n, {bif.busKind, bif.busHighByte});
        end
        bif.euKind = 2'b11;
        bif.euWord = 1'b0;
        serve(4);
        checks++;
        if ({bif.busStart, bif.busKind, bif.busHighByte, bif.euAck} !== 6'b101010) begin
            errors++;
            $display("FAIL euword_hi: start/kind/hi/ack got %b want 101010",
                     {bif.busStart, bif.busKind, bif.busHighByte, bif.euAck});
        end
        serve(4);
        checks++;
        if ({bif.busStart, bif.euAck} !== 2'b01) begin
            errors++;
            $display("FAIL euword_ack: start/ack got %b want 01", {bif.busStart, bif.euAck});
        end
        bif.euReq = 1'b0;
        repeat (3) tick();
        checks++;
        if ((nStart - s0) !== 2 || (nEuAck - a0) !== 1) begin
            errors++;
            $display("FAIL euword_counts: starts %0d acks %0d want 2 1", nStart - s0, nEuAck - a0);
        end
    endtask

    task automatic test_priority();
        int n;
        bif.intaReq = 1'b1;
        bif.euReq   = 1'b1;
        bif.euKind  = 2'b00;
        bif.euWord  = 1'b0;
        bif.qFull   = 1'b0;
        wait_start(10, n);
        checks++;
        if (n !== 1 || bif.busKind !== 3'b101) begin
            errors++;
            $display("FAIL prio_inta1: wait %0d kind %b want wait 1 kind 101", n, bif.busKind);
        end
        serve(2);
        checks++;
        if ({bif.busStart, bif.busKind, bif.intaAck} !== 5'b11010) begin
            errors++;
            $display("FAIL prio_inta2: start/kind/ack got %b want 11010", {bif.busStart, bif.busKind, bif.intaAck});
        end
        serve(3);
        checks++;
        if ({bif.busStart, bif.intaAck} !== 2'b01) begin
            errors++;
            $display("FAIL prio_inta_ack: start/ack got %b want 01", {bif.busStart, bif.intaAck});
        end
        bif.intaReq = 1'b0;
        tick();
        checks++;
        if ({bif.busStart, bif.busKind, bif.busHighByte} !== 5'b10010) begin
            errors++;
            $display("FAIL prio_eu_after_turnaround: got %b want 10010", {bif.busStart, bif.busKind, bif.busHighByte});
        end
        serve(2);
        bif.euReq = 1'b0;
        tick();
        checks++;
        if ({bif.busStart, bif.busKind} !== 4'b1000) begin
            errors++;
            $display("FAIL prio_fetch_last: start/kind got %b want 1000", {bif.busStart, bif.busKind});
        end
        bif.qFull = 1'b1;
        serve(1);
        repeat (2) tick();
    endtask

    task automatic test_hold_mid_word();
        int n;
        int s0;
        bif.euReq  = 1'b1;
        bif.euKind = 2'b10;
        bif.euWord = 1'b1;
        wait_start(10, n);
        checks++;
        if (n !== 1 || bif.busKind !== 3'b011) begin
            errors++;
            $display("FAIL hold_eu_lo: wait %0d kind %b want wait 1 kind 011", n, bif.busKind);
        end
        bif.HOLD = 1'b1;
        serve(3);
        checks++;
        if ({bif.busStart, bif.busHighByte, bif.HOLDA} !== 3'b110) begin
            errors++;
            $display("FAIL hold_deferred_hi: start/hi/holda got %b want 110", {bif.busStart, bif.busHighByte, bif.HOLDA});
        end
        serve(3);
        checks++;
        if ({bif.euAck, bif.HOLDA} !== 2'b10) begin
            errors++;
            $display("FAIL hold_after_ack: ack/holda got %b want 10", {bif.euAck, bif.HOLDA});
        end
        bif.euReq = 1'b0;
        tick();
        s0 = nStart;
        repeat (5) tick();
        checks++;
        if (bif.HOLDA !== 1'b1 || (nStart - s0) !== 0) begin
            errors++;
            $display("FAIL hold_granted: holda %b starts %0d want 1 0", bif.HOLDA, nStart - s0);
        end
        bif.HOLD  = 1'b0;
        bif.qFull = 1'b0;
        tick();
        checks++;
        if ({bif.HOLDA, bif.busStart} !== 2'b00) begin
            errors++;
            $display("FAIL hold_release: holda/start got %b want 00", {bif.HOLDA, bif.busStart});
        end
        tick();
        checks++;
        if ({bif.busStart, bif.busKind} !== 4'b1000) begin
            errors++;
            $display("FAIL hold_then_fetch: start/kind got %b want 1000", {bif.busStart, bif.busKind});
        end
        bif.qFull = 1'b1;
        serve(1);
        repeat (2) tick();
    endtask

    task automatic test_qfull();
        int n;
        int s0 = nStart;
        bif.qFull = 1'b1;
        repeat (25) tick();
        bif.qFull   = 1'b0;
        bif.suspend = 1'b1;
        repeat (25) tick();
        checks++;
        if ((nStart - s0) !== 0 || bif.busStart !== 1'b0) begin
            errors++;
            $display("FAIL qfull_suspend_quiet: starts %0d want 0", nStart - s0);
        end
        bif.suspend = 1'b0;
        wait_start(10, n);
        checks++;
        if (n !== 1 || bif.busKind !== 3'b000) begin
            errors++;
            $display("FAIL qfull_release_fetch: wait %0d kind %b want wait 1 kind 000", n, bif.busKind);
        end
        bif.qFull = 1'b1;
        serve(2);
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int n;
        int a0 = nEuAck;
        bif.euReq  = 1'b1;
        bif.euKind = 2'b01;
        bif.euWord = 1'b1;
        wait_start(10, n);
        serve(2);
        checks++;
        if ({bif.busStart, bif.busHighByte} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_in_hi: start/hi got %b want 11", {bif.busStart, bif.busHighByte});
        end
        tick();
        #2;
        RESET_n = 1'b0;
        #1;
        checks++;
        if ({bif.busStart, bif.busKind, bif.busHighByte, bif.euAck, bif.intaAck, bif.HOLDA} !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async_clear: got %b want 00000000",
                     {bif.busStart, bif.busKind, bif.busHighByte, bif.euAck, bif.intaAck, bif.HOLDA});
        end
        repeat (2) @(posedge CLKx4);
        #1;
        RESET_n = 1'b1;
        tick();
        checks++;
        if (bif.busStart !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first_edge: busStart got %b want 0", bif.busStart);
        end
        tick();
        checks++;
        if ({bif.busStart, bif.busKind, bif.busHighByte} !== 5'b10100) begin
            errors++;
            $display("FAIL rstmid_fresh_lo: start/kind/hi got %b want 10100", {bif.busStart, bif.busKind, bif.busHighByte});
        end
        serve(2);
        serve(2);
        bif.euReq = 1'b0;
        tick();
        checks++;
        if ((nEuAck - a0) !== 1) begin
            errors++;
            $display("FAIL rstmid_ack_count: acks %0d want 1", nEuAck - a0);
        end
        tick();
    endtask

    task automatic test_lock();
        bif.HOLD   = 1'b1;
        bif.lockIn = 1'b1;
`ifdef BUS_ARB_LOCK_EN
        begin
            int seen = 0;
            repeat (20) begin
                tick();
                if (bif.HOLDA === 1'b1) seen++;
            end
            checks++;
            if (seen !== 0) begin
                errors++;
                $display("FAIL lock_blocks_holda: HOLDA high in %0d cycles want 0", seen);
            end
            bif.lockIn = 1'b0;
            tick();
        end
`else
        tick();
`endif
        checks++;
        if (bif.HOLDA !== 1'b1) begin
            errors++;
            $display("FAIL lock_holda_grant: HOLDA got %b want 1", bif.HOLDA);
        end
        bif.HOLD   = 1'b0;
        bif.lockIn = 1'b0;
        tick();
        checks++;
        if (bif.HOLDA !== 1'b0) begin
            errors++;
            $display("FAIL lock_holda_release: HOLDA got %b want 0", bif.HOLDA);
        end
        tick();
    endtask

    task automatic test_cancel();
        int s0 = nStart;
        int a0 = nEuAck;
        int i0 = nIntaAck;
        bif.HOLD    = 1'b1;
        bif.intaReq = 1'b1;
        tick();
        checks++;
        if ({bif.HOLDA, bif.busStart} !== 2'b10) begin
            errors++;
            $display("FAIL cancel_hold_over_inta: holda/start got %b want 10", {bif.HOLDA, bif.busStart});
        end
        bif.euReq = 1'b1;
        tick();
        bif.intaReq = 1'b0;
        bif.euReq   = 1'b0;
        tick();
        bif.HOLD = 1'b0;
        repeat (6) tick();
        bif.busDone = 1'b1;
        tick();
        bif.busDone = 1'b0;
        repeat (4) tick();
        checks++;
        if ((nStart - s0) !== 0 || (nEuAck - a0) !== 0 || (nIntaAck - i0) !== 0) begin
            errors++;
            $display("FAIL cancel_no_cycle: starts %0d euAcks %0d intaAcks %0d want 0 0 0",
                     nStart - s0, nEuAck - a0, nIntaAck - i0);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        for (int it = 0; it < 30; it++) begin
            int n;
            int lat;
            int s0;
            bit doInta = 1'($urandom_range(0, 1));
            bit doEu   = 1'($urandom_range(0, 1));
            bit doFetch = 1'($urandom_range(0, 1));
            logic [1:0] k = 2'($urandom_range(0, 3));
            logic w = 1'($urandom_range(0, 1));
            if (!doInta && !doEu) doFetch = 1'b1;
            q.delete();
            if (doInta) begin
                e = '{3'b101, 1'b0, 1, 0}; q.push_back(e);
                e = '{3'b101, 1'b0, 0, 2}; q.push_back(e);
            end
            if (doEu) begin
                e = '{3'({1'b0, k} + 3'b001), 1'b0, 1, (w ? 0 : 1)}; q.push_back(e);
                if (w) begin
                    e = '{3'({1'b0, k} + 3'b001), 1'b1, 0, 1}; q.push_back(e);
                end
            end
            if (doFetch) begin
                e = '{3'b000, 1'b0, 1, 0}; q.push_back(e);
            end
            s0 = nStart;
            bif.intaReq = doInta;
            bif.euReq   = doEu;
            bif.euKind  = k;
            bif.euWord  = w;
            bif.qFull   = !doFetch;
            foreach (q[i]) begin
                wait_start(8, n);
                checks++;
                if (n !== q[i].gap || {bif.busKind, bif.busHighByte} !== {q[i].kind, q[i].hi}) begin
                    errors++;
                    $display("FAIL rnd_start it%0d #%0d: wait %0d kind/hi %b want wait %0d kind/hi %b",
                             it, i, n, {bif.busKind, bif.busHighByte}, q[i].gap, {q[i].kind, q[i].hi});
                end
                if (q[i].kind == 3'b000) bif.qFull = 1'b1;
                if (q[i].kind != 3'b000 && q[i].kind != 3'b101) begin
                    bif.euKind = 2'($urandom_range(0, 3));
                    bif.euWord = 1'($urandom_range(0, 1));
                end
                lat = $urandom_range(1, 5);
                for (int j = 1; j < lat; j++) begin
                    tick();
                    checks++;
                    if ({bif.busStart, bif.busKind} !== {1'b0, q[i].kind}) begin
                        errors++;
                        $display("FAIL rnd_stable it%0d #%0d: start/kind %b want %b",
                                 it, i, {bif.busStart, bif.busKind}, {1'b0, q[i].kind});
                    end
                end
                bif.busDone = 1'b1;
                tick();
                bif.busDone = 1'b0;
                checks++;
                if ({bif.euAck, bif.intaAck} !== {q[i].ack == 1, q[i].ack == 2}) begin
                    errors++;
                    $display("FAIL rnd_ack it%0d #%0d: euAck/intaAck %b want %b",
                             it, i, {bif.euAck, bif.intaAck}, {q[i].ack == 1, q[i].ack == 2});
                end
                if (q[i].ack == 1) bif.euReq = 1'b0;
                if (q[i].ack == 2) bif.intaReq = 1'b0;
            end
            bif.euReq   = 1'b0;
            bif.intaReq = 1'b0;
            bif.qFull   = 1'b1;
            repeat (3) tick();
            checks++;
            if ((nStart - s0) !== q.size()) begin
                errors++;
                $display("FAIL rnd_count it%0d: starts %0d want %0d", it, nStart - s0, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_eu_word();
        test_priority();
        test_hold_mid_word();
        test_qfull();
        test_reset_mid();
        test_lock();
        test_cancel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
